// File: rtl/sample_fifo_pkg.sv
// rtl/sample_fifo_pkg.sv - shared constants and pointer-state type for the multi-channel sample FIFO
package sample_fifo_pkg;

    localparam int RD_LAT    = 2;
    localparam int PTR_W_MAX = 16;

    // Pointer fields are sized for the widest supported depth; each channel masks to its own width.
    typedef struct packed {
        logic [PTR_W_MAX-1:0] wptr;
        logic [PTR_W_MAX-1:0] rptr;
        logic [PTR_W_MAX-1:0] mark;
        logic                 mark_en;
    } ch_ptr_t;

endpackage

// File: rtl/sample_fifo_ptr.sv
// rtl/sample_fifo_ptr.sv - per-channel pointers, mark/rewind priority and flag generation
module sample_fifo_ptr
    import sample_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH_BIT = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push_req,
    input  logic                      pop_req,
    input  logic                      mark,
    input  logic                      rel,
    input  logic                      rewind,
    output logic                      full,
    output logic                      empty,
    output logic                      push_ok,
    output logic                      pop_ok,
    output logic                      push_drop,
    output logic [FIFO_DEPTH_BIT-1:0] wr_idx,
    output logic [FIFO_DEPTH_BIT-1:0] rd_idx,
    output logic [FIFO_DEPTH_BIT:0]   level
);

    localparam int PW = FIFO_DEPTH_BIT + 1;
    localparam logic [PTR_W_MAX-1:0] MASK  = PTR_W_MAX'((32'd1 << PW) - 32'd1);
    localparam logic [PTR_W_MAX-1:0] DEPTH = PTR_W_MAX'(32'd1 << FIFO_DEPTH_BIT);
    localparam logic [PTR_W_MAX-1:0] ONE   = PTR_W_MAX'(1);

    ch_ptr_t ptr_q;
    ch_ptr_t ptr_d;

    assign empty  = (ptr_q.wptr == ptr_q.rptr);
    assign full   = (((ptr_q.wptr - ptr_q.mark) & MASK) == DEPTH);
    assign level  = PW'((ptr_q.wptr - ptr_q.rptr) & MASK);
    assign wr_idx = ptr_q.wptr[FIFO_DEPTH_BIT-1:0];
    assign rd_idx = ptr_q.rptr[FIFO_DEPTH_BIT-1:0];

    assign push_ok   = push_req && !full && !flush;
    assign push_drop = push_req && full && !flush;
    assign pop_ok    = pop_req && !empty && !flush && !rewind;

    always_comb begin
        ptr_d = ptr_q;
        if (flush) begin
            ptr_d = '0;
        end else begin
            if (push_ok)
                ptr_d.wptr = (ptr_q.wptr + ONE) & MASK;
            // A mark taken in the same cycle as a rewind pins rptr where it is.
            if (rewind) begin
                if (!mark)
                    ptr_d.rptr = ptr_q.mark;
            end else if (pop_ok) begin
                ptr_d.rptr = (ptr_q.rptr + ONE) & MASK;
            end
            if (mark) begin
                ptr_d.mark    = ptr_q.rptr;
                ptr_d.mark_en = 1'b1;
            end else if (rel) begin
                ptr_d.mark_en = 1'b0;
            end
            if (!ptr_d.mark_en)
                ptr_d.mark = ptr_d.rptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sample_fifo_mc.sv
// rtl/sample_fifo_mc.sv - multi-channel sample buffer with mark/rewind replay over one shared RAM
module sample_fifo_mc
    import sample_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH     = 16,
    parameter int FIFO_DEPTH_BIT = 5,
    parameter int N_CH           = 4,
    parameter int CH_BIT         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_CH-1:0]                    i_flush,
    input  logic                               i_push,
    input  logic [CH_BIT-1:0]                  i_push_ch,
    input  logic [FIFO_WIDTH-1:0]              i_rear,
    output logic                               o_push_drop,
    input  logic                               i_pop,
    input  logic [CH_BIT-1:0]                  i_pop_ch,
    output logic [FIFO_WIDTH-1:0]              o_front,
    output logic [CH_BIT-1:0]                  o_front_ch,
    output logic                               o_vld,
    input  logic [N_CH-1:0]                    i_mark,
    input  logic [N_CH-1:0]                    i_release,
    input  logic [N_CH-1:0]                    i_rewind,
    output logic [N_CH-1:0]                    o_full,
    output logic [N_CH-1:0]                    o_empty,
    output logic [N_CH*(FIFO_DEPTH_BIT+1)-1:0] o_level
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_BIT;
    localparam int AW    = CH_BIT + FIFO_DEPTH_BIT;
    localparam int LW    = FIFO_DEPTH_BIT + 1;

    logic [N_CH-1:0]           push_ok;
    logic [N_CH-1:0]           pop_ok;
    logic [N_CH-1:0]           push_drop;
    logic [FIFO_DEPTH_BIT-1:0] wr_idx [N_CH];
    logic [FIFO_DEPTH_BIT-1:0] rd_idx [N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        sample_fifo_ptr #(.FIFO_DEPTH_BIT(FIFO_DEPTH_BIT)) u_ptr (
            .clk       (clk),
            .rst       (rst),
            .flush     (i_flush[c]),
            .push_req  (i_push && (i_push_ch == CH_BIT'(c))),
            .pop_req   (i_pop && (i_pop_ch == CH_BIT'(c))),
            .mark      (i_mark[c]),
            .rel       (i_release[c]),
            .rewind    (i_rewind[c]),
            .full      (o_full[c]),
            .empty     (o_empty[c]),
            .push_ok   (push_ok[c]),
            .pop_ok    (pop_ok[c]),
            .push_drop (push_drop[c]),
            .wr_idx    (wr_idx[c]),
            .rd_idx    (rd_idx[c]),
            .level     (o_level[c*LW +: LW])
        );
    end

    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (push_ok[c]) begin
                wr_en   = 1'b1;
                wr_addr = {CH_BIT'(c), wr_idx[c]};
            end
            if (pop_ok[c]) begin
                rd_en   = 1'b1;
                rd_addr = {CH_BIT'(c), rd_idx[c]};
            end
        end
    end

    // Kept free of reset so the array and its read register map onto block RAM.
    logic [FIFO_WIDTH-1:0] mem [N_CH*DEPTH];
    logic [FIFO_WIDTH-1:0] ram_q;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= i_rear;
        if (rd_en)
            ram_q <= mem[rd_addr];
    end

    logic [RD_LAT-1:0] vld_pipe;
    logic [CH_BIT-1:0] ch_pipe [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe    <= '0;
            o_front     <= '0;
            o_push_drop <= 1'b0;
            for (int i = 0; i < RD_LAT; i++)
                ch_pipe[i] <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[RD_LAT-2:0], rd_en};
            o_push_drop <= |push_drop;
            ch_pipe[0]  <= i_pop_ch;
            for (int i = 1; i < RD_LAT; i++)
                ch_pipe[i] <= ch_pipe[i-1];
            if (vld_pipe[RD_LAT-2])
                o_front <= ram_q;
        end
    end

    assign o_vld      = vld_pipe[RD_LAT-1];
    assign o_front_ch = ch_pipe[RD_LAT-1];

endmodule

// File: tb/tb_sample_fifo_mc.sv
// tb/tb_sample_fifo_mc.sv - directed vector bench for sample_fifo_mc
`timescale 1ns/1ps
module tb_sample_fifo_mc;

    localparam int W  = 16;
    localparam int DB = 3;
    localparam int NC = 2;
    localparam int CB = 1;
    localparam int LW = DB + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     i_flush, i_mark, i_release, i_rewind;
    logic              i_push, i_pop;
    logic [CB-1:0]     i_push_ch, i_pop_ch;
    logic [W-1:0]      i_rear;
    logic              o_push_drop, o_vld;
    logic [W-1:0]      o_front;
    logic [CB-1:0]     o_front_ch;
    logic [NC-1:0]     o_full, o_empty;
    logic [NC*LW-1:0]  o_level;

    always #5 clk = ~clk;

    sample_fifo_mc #(
        .FIFO_WIDTH(W), .FIFO_DEPTH_BIT(DB), .N_CH(NC), .CH_BIT(CB)
    ) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_push(i_push), .i_push_ch(i_push_ch),
        .i_rear(i_rear), .o_push_drop(o_push_drop), .i_pop(i_pop), .i_pop_ch(i_pop_ch),
        .o_front(o_front), .o_front_ch(o_front_ch), .o_vld(o_vld), .i_mark(i_mark),
        .i_release(i_release), .i_rewind(i_rewind), .o_full(o_full), .o_empty(o_empty),
        .o_level(o_level)
    );

    typedef struct {
        logic        push;
        logic        pch;
        logic [15:0] rear;
        logic        pop;
        logic        och;
        logic [1:0]  mark, rel, rew, flush;
        logic        vld;
        logic [15:0] front;
        logic        fch;
        logic        drop;
        logic [1:0]  full, empty;
        logic [7:0]  level;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(input logic push, input logic pch, input logic [15:0] rear,
                                input logic pop, input logic och,
                                input logic [1:0] mark, input logic [1:0] rel,
                                input logic [1:0] rew, input logic [1:0] flush,
                                input logic vld, input logic [15:0] front, input logic fch,
                                input logic drop, input logic [1:0] full, input logic [1:0] empty,
                                input int l0, input int l1);
        vec_t v;
        v.push = push; v.pch = pch; v.rear = rear; v.pop = pop; v.och = och;
        v.mark = mark; v.rel = rel; v.rew = rew; v.flush = flush;
        v.vld = vld; v.front = front; v.fch = fch; v.drop = drop;
        v.full = full; v.empty = empty; v.level = {4'(l1), 4'(l0)};
        tbl.push_back(v);
    endfunction

    task automatic clr();
        i_flush = '0; i_mark = '0; i_release = '0; i_rewind = '0;
        i_push = 1'b0; i_push_ch = '0; i_rear = '0; i_pop = 1'b0; i_pop_ch = '0;
    endtask

    task automatic drive(input vec_t v);
        i_push = v.push; i_push_ch = v.pch; i_rear = v.rear;
        i_pop = v.pop; i_pop_ch = v.och;
        i_mark = v.mark; i_release = v.rel; i_rewind = v.rew; i_flush = v.flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pt(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        chk(name, act, exp);
    endtask

    task automatic chk_reset_state(input string tag);
        pt({tag, "_vld"},   16'(o_vld), 16'h0);
        pt({tag, "_front"}, o_front, 16'h0);
        pt({tag, "_fch"},   16'(o_front_ch), 16'h0);
        pt({tag, "_drop"},  16'(o_push_drop), 16'h0);
        pt({tag, "_empty"}, 16'(o_empty), 16'h3);
        pt({tag, "_full"},  16'(o_full), 16'h0);
        pt({tag, "_level"}, 16'(o_level), 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst_hold");
        rst = 1'b0;
        tick();
        chk_reset_state("rst_idle");

        // Fill/drain ch0, overflow on the ninth push.
        for (int i = 0; i < 8; i++)
            add(1, 0, 16'(16'h10 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 7) ? 2'b01 : 2'b00, 2'b10, i + 1, 0);
        add(1, 0, 16'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b10, 8, 0);
        for (int j = 0; j < 8; j++)
            add(0, 0, 0, 1, 0, 0, 0, 0, 0, j > 0, 16'(16'h10 + j - 1), 0, 0, 2'b00, (j == 7) ? 2'b11 : 2'b10, 7 - j, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h17, 0, 0, 2'b00, 2'b11, 0, 0);

        // Channel isolation.
        add(1, 0, 16'hA0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0);
        add(1, 1, 16'hB0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        add(1, 0, 16'hA1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 1);
        add(1, 1, 16'hB1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 2);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'hB0, 1, 0, 2'b00, 2'b00, 1, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 16'hA0, 0, 0, 2'b00, 2'b10, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'hB1, 1, 0, 2'b00, 2'b11, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hA1, 0, 0, 2'b00, 2'b11, 0, 0);

        // Mark/rewind replay on ch1, then retention-aware full and release.
        for (int i = 0; i < 4; i++)
            add(1, 1, 16'(16'hC0 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, i + 1);
        add(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 4);
        for (int k = 0; k < 4; k++)
            add(0, 0, 0, 1, 1, 0, 0, 0, 0, k > 0, 16'(16'hC0 + k - 1), 1, 0, 2'b00, (k == 3) ? 2'b11 : 2'b01, 0, 3 - k);
        add(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 1, 16'hC3, 1, 0, 2'b00, 2'b01, 0, 4);
        for (int k = 0; k < 4; k++)
            add(0, 0, 0, 1, 1, 0, 0, 0, 0, k > 0, 16'(16'hC0 + k - 1), 1, 0, 2'b00, (k == 3) ? 2'b11 : 2'b01, 0, 3 - k);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hC3, 1, 0, 2'b00, 2'b11, 0, 0);
        for (int i = 0; i < 4; i++)
            add(1, 1, 16'(16'hD0 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 3) ? 2'b10 : 2'b00, 2'b01, 0, i + 1);
        add(1, 1, 16'hEE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 0, 4);
        add(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 4);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 3);
        add(1, 1, 16'hE1, 0, 0, 0, 0, 0, 0, 1, 16'hD0, 1, 0, 2'b00, 2'b01, 0, 4);
        for (int k = 0; k < 4; k++)
            add(0, 0, 0, 1, 1, 0, 0, 0, 0, k > 0, 16'(16'hD0 + k), 1, 0, 2'b00, (k == 3) ? 2'b11 : 2'b01, 0, 3 - k);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hE1, 1, 0, 2'b00, 2'b11, 0, 0);

        // Wrap-around on ch0: three rounds of five.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++)
                add(1, 0, 16'(16'h50 + r * 5 + i), 0, 0, 0, 0, 0, 0, (r > 0) && (i == 0), 16'(16'h50 + r * 5 - 1), 0, 0, 2'b00, 2'b10, i + 1, 0);
            for (int k = 0; k < 5; k++)
                add(0, 0, 0, 1, 0, 0, 0, 0, 0, k > 0, 16'(16'h50 + r * 5 + k - 1), 0, 0, 2'b00, (k == 4) ? 2'b11 : 2'b10, 4 - k, 0);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h5E, 0, 0, 2'b00, 2'b11, 0, 0);

        // Flush ch0 with ch1 holding data; same-cycle push to ch0 drops silently.
        add(1, 0, 16'h70, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0);
        add(1, 0, 16'h71, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2, 0);
        add(1, 1, 16'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 1);
        add(1, 1, 16'h81, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 2);
        add(1, 0, 16'h72, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b01, 0, 2);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 2);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 16'h80, 1, 0, 2'b00, 2'b11, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h81, 1, 0, 2'b00, 2'b11, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            tick();
            n_vec++;
            chk($sformatf("v%0d_vld", i), 16'(o_vld), 16'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("v%0d_front", i), o_front, tbl[i].front);
                chk($sformatf("v%0d_fch", i), 16'(o_front_ch), 16'(tbl[i].fch));
            end
            chk($sformatf("v%0d_drop", i), 16'(o_push_drop), 16'(tbl[i].drop));
            chk($sformatf("v%0d_full", i), 16'(o_full), 16'(tbl[i].full));
            chk($sformatf("v%0d_empty", i), 16'(o_empty), 16'(tbl[i].empty));
            chk($sformatf("v%0d_level", i), 16'(o_level), 16'(tbl[i].level));
        end

        // Rewind and pop in the same cycle: rewind wins, the pop yields nothing.
        clr(); i_push = 1'b1; i_rear = 16'h90; tick();
        i_rear = 16'h91; tick();
        clr(); i_mark = 2'b01; tick();
        clr(); i_pop = 1'b1; tick();
        pt("rw_pop_level", 16'(o_level[3:0]), 16'd1);
        clr(); i_rewind = 2'b01; i_pop = 1'b1; tick();
        pt("rw_same_level", 16'(o_level[3:0]), 16'd2);
        pt("rw_same_vld", 16'(o_vld), 16'h1);
        pt("rw_same_front", o_front, 16'h90);
        clr(); tick();
        pt("rw_no_vld", 16'(o_vld), 16'h0);
        i_pop = 1'b1; tick();
        tick();
        pt("rw_replay0_vld", 16'(o_vld), 16'h1);
        pt("rw_replay0", o_front, 16'h90);
        clr(); tick();
        pt("rw_replay1", o_front, 16'h91);
        pt("rw_drained", 16'(o_empty), 16'h3);
        i_release = 2'b01; tick();
        clr();

        // Reset with pops in flight.
        i_push = 1'b1; i_push_ch = 1'b1;
        i_rear = 16'hA5; tick();
        i_rear = 16'hA6; tick();
        i_rear = 16'hA7; tick();
        clr(); i_pop = 1'b1; i_pop_ch = 1'b1; tick();
        tick();
        pt("pre_rst_vld", 16'(o_vld), 16'h1);
        pt("pre_rst_front", o_front, 16'hA5);
        pt("pre_rst_fch", 16'(o_front_ch), 16'h1);
        clr();
        #2 rst = 1'b1;
        #1;
        chk_reset_state("rst_async");
        #1 rst = 1'b0;
        tick();
        pt("rst_flushed_vld", 16'(o_vld), 16'h0);
        pt("rst_flushed_empty", 16'(o_empty), 16'h3);
        tick();
        pt("rst_flushed_vld2", 16'(o_vld), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
